// File: rtl/input_debounce_bank.sv
// Multi-channel input debouncer: synchroniser, stability counter, edge pulses.
// Optional sticky edge capture and masked interrupt when DEBOUNCE_CAPTURE_IRQ_EN is defined.
module input_debounce_bank #(
  parameter int unsigned CHANNELS    = 5,
  parameter int unsigned CNT_W       = 20,
  parameter int unsigned STABLE_CNT  = 500000,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_LEVEL = 1'b0
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [CHANNELS-1:0] i_raw,
  output logic [CHANNELS-1:0] o_level,
  output logic [CHANNELS-1:0] o_rise,
  output logic [CHANNELS-1:0] o_fall,
  input  logic [CHANNELS-1:0] i_clr,
  input  logic [CHANNELS-1:0] i_irq_mask,
  output logic [CHANNELS-1:0] o_capture,
  output logic                o_irq
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT - 1);

  // Reject configurations the counter or synchroniser cannot honour.
  generate
    if (STABLE_CNT == 0 || 64'(STABLE_CNT) > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_stable
      $error("input_debounce_bank: STABLE_CNT must be in 1 .. 2^CNT_W-1");
    end
    if (CHANNELS == 0 || CHANNELS > 32) begin : g_bad_channels
      $error("input_debounce_bank: CHANNELS must be in 1 .. 32");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("input_debounce_bank: SYNC_STAGES must be in 2 .. 4");
    end
  endgenerate

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] sync_c;
  logic [CNT_W-1:0]    cnt_q  [CHANNELS];
  logic [CNT_W-1:0]    cnt_d  [CHANNELS];
  logic [CHANNELS-1:0] level_d;
  logic [CHANNELS-1:0] rise_d;
  logic [CHANNELS-1:0] fall_d;

  assign sync_c = sync_q[SYNC_STAGES-1];

  // Metastability chain on the raw asynchronous inputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= {CHANNELS{RESET_LEVEL}};
      end
    end else begin
      sync_q[0] <= i_raw;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  // Per-channel stability count; accept the new level once it has held long enough.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = o_level;
    rise_d  = '0;
    fall_d  = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      if (sync_c[n] == o_level[n]) begin
        cnt_d[n] = '0;
      end else if (cnt_q[n] == CNT_MAX) begin
        cnt_d[n]   = '0;
        level_d[n] = sync_c[n];
        rise_d[n]  = sync_c[n];
        fall_d[n]  = ~sync_c[n];
      end else begin
        cnt_d[n] = cnt_q[n] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int n = 0; n < CHANNELS; n++) begin
        cnt_q[n] <= '0;
      end
      o_level <= {CHANNELS{RESET_LEVEL}};
      o_rise  <= '0;
      o_fall  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      o_level <= level_d;
      o_rise  <= rise_d;
      o_fall  <= fall_d;
    end
  end

`ifdef DEBOUNCE_CAPTURE_IRQ_EN
  // Sticky edge capture (a new edge beats a clear) and masked level interrupt.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_capture <= '0;
      o_irq     <= 1'b0;
    end else begin
      o_capture <= (o_capture & ~i_clr) | o_rise | o_fall;
      o_irq     <= |(o_capture & i_irq_mask);
    end
  end
`else
  logic unused_capture_inputs;
  assign unused_capture_inputs = ^{i_clr, i_irq_mask};
  assign o_capture = '0;
  assign o_irq     = 1'b0;
`endif

endmodule

// File: tb/tb_input_debounce_bank.sv
// Randomised and directed bench for input_debounce_bank against a cycle-level reference model.
module tb_input_debounce_bank;

  localparam int unsigned C      = 5;
  localparam int unsigned STABLE = 4;
  localparam int unsigned SYNC   = 2;
`ifdef DEBOUNCE_CAPTURE_IRQ_EN
  localparam bit CAP_EN = 1'b1;
`else
  localparam bit CAP_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [C-1:0] raw = '0;
  logic [C-1:0] clr = '0;
  logic [C-1:0] mask = '0;
  logic [C-1:0] level, rise, fall, cap;
  logic         irq;

  int n_tests = 0;
  int n_fail  = 0;

  input_debounce_bank #(
    .CHANNELS(C), .CNT_W(8), .STABLE_CNT(STABLE), .SYNC_STAGES(SYNC), .RESET_LEVEL(1'b0)
  ) dut (
    .clk(clk), .rstn(rstn), .i_raw(raw), .o_level(level), .o_rise(rise), .o_fall(fall),
    .i_clr(clr), .i_irq_mask(mask), .o_capture(cap), .o_irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: raw samples age through a delay queue; a channel flips after
  // STABLE consecutive delayed samples disagreeing with its current level.
  logic [C-1:0] m_hist[$];
  logic [C-1:0] m_level, m_rise, m_fall, m_cap;
  logic         m_irq;
  int           m_run[C];

  task automatic model_reset();
    m_hist = {};
    for (int i = 0; i < SYNC; i++) m_hist.push_back('0);
    m_level = '0; m_rise = '0; m_fall = '0; m_cap = '0; m_irq = 1'b0;
    for (int n = 0; n < C; n++) m_run[n] = 0;
  endtask

  // One clock: inputs are stable (driven at negedge), model follows the edge, return at negedge.
  task automatic step();
    logic [C-1:0] sync_v, rise_p, fall_p, cap_p;
    @(posedge clk);
    rise_p = m_rise; fall_p = m_fall; cap_p = m_cap;
    if (!rstn) begin
      model_reset();
    end else begin
      sync_v = m_hist[0];
      m_hist.push_back(raw);
      void'(m_hist.pop_front());
      m_rise = '0; m_fall = '0;
      for (int n = 0; n < C; n++) begin
        if (sync_v[n] == m_level[n]) m_run[n] = 0;
        else begin
          m_run[n]++;
          if (m_run[n] == STABLE) begin
            m_level[n] = sync_v[n];
            m_rise[n]  = sync_v[n];
            m_fall[n]  = ~sync_v[n];
            m_run[n]   = 0;
          end
        end
      end
      if (CAP_EN) begin
        m_cap = (cap_p & ~clr) | rise_p | fall_p;
        m_irq = |(cap_p & mask);
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstn = 1'b0; raw = '0; clr = '0; mask = '0;
    step(); step();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; raw = 5'b10110; clr = '0; mask = '1;
    for (int i = 0; i < 8; i++) begin
      step();
      n_tests++;
      if ({level, rise, fall, cap, irq} !== '0) begin
        n_fail++;
        $display("FAIL reset cyc=%0d got lvl=%b r=%b f=%b cap=%b irq=%b exp all 0", i, level, rise, fall, cap, irq);
      end
    end
  endtask

  task automatic test_step();
    do_reset();
    raw[0] = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step();
      n_tests++;
      if (rise[0] !== (e == 6) || level[0] !== (e == 6) || fall[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL step_edge e=%0d got r=%b l=%b f=%b exp r=l=%b f=0", e, rise[0], level[0], fall[0], e == 6);
      end
    end
    step();
    n_tests++;
    if (rise[0] !== 1'b0 || cap[0] !== CAP_EN || level[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL step_after got r=%b cap=%b l=%b exp r=0 cap=%b l=1", rise[0], cap[0], level[0], CAP_EN);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    raw[1] = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i == 3) raw[1] = 1'b0;
      step();
      n_tests++;
      if ({level[1], rise[1], fall[1], cap[1]} !== 4'b0) begin
        n_fail++;
        $display("FAIL glitch cyc=%0d got l=%b r=%b f=%b cap=%b exp 0", i, level[1], rise[1], fall[1], cap[1]);
      end
    end
  endtask

  task automatic test_coincident();
    int k;
    do_reset();
    raw[2] = 1'b1;
    k = 0;
    while (rise[2] !== 1'b1 && k < 20) begin step(); k++; end
    raw[2] = 1'b0;
    step();
    clr[2] = 1'b1;
    step();
    clr[2] = 1'b0;
    n_tests++;
    if (cap[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL coinc_preclear got cap=%b exp 0", cap[2]);
    end
    k = 0;
    while (fall[2] !== 1'b1 && k < 20) begin step(); k++; end
    n_tests++;
    if (fall[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL coinc_fall_timeout got f=%b exp 1", fall[2]);
    end
    clr[2] = 1'b1;
    step();
    n_tests++;
    if (cap[2] !== CAP_EN) begin
      n_fail++;
      $display("FAIL coinc_setwins got cap=%b exp %b", cap[2], CAP_EN);
    end
    step();
    clr[2] = 1'b0;
    n_tests++;
    if (cap[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL coinc_clear got cap=%b exp 0", cap[2]);
    end
  endtask

  task automatic test_mask();
    int k;
    do_reset();
    raw[3] = 1'b1;
    k = 0;
    while (rise[3] !== 1'b1 && k < 20) begin step(); k++; end
    step();
    step();
    n_tests++;
    if (cap[3] !== CAP_EN || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL mask_off got cap=%b irq=%b exp cap=%b irq=0", cap[3], irq, CAP_EN);
    end
    mask = 5'b01000;
    step();
    n_tests++;
    if (irq !== CAP_EN) begin
      n_fail++;
      $display("FAIL mask_on got irq=%b exp %b", irq, CAP_EN);
    end
    clr[3] = 1'b1;
    step();
    clr[3] = 1'b0;
    n_tests++;
    if (cap[3] !== 1'b0 || irq !== CAP_EN) begin
      n_fail++;
      $display("FAIL mask_clr got cap=%b irq=%b exp cap=0 irq=%b", cap[3], irq, CAP_EN);
    end
    step();
    n_tests++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL mask_irq_drop got irq=%b exp 0", irq);
    end
  endtask

  task automatic test_reset_midcount();
    do_reset();
    raw[4] = 1'b1;
    repeat (5) step();
    n_tests++;
    if (level[4] !== 1'b0 || rise[4] !== 1'b0) begin
      n_fail++;
      $display("FAIL midcnt_pre got l=%b r=%b exp 0 0", level[4], rise[4]);
    end
    rstn = 1'b0;
    step(); step();
    rstn = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step();
      n_tests++;
      if (rise[4] !== (e == 6)) begin
        n_fail++;
        $display("FAIL midcnt_rise e=%0d got r=%b exp %b", e, rise[4], e == 6);
      end
    end
  endtask

  task automatic test_all_channels();
    do_reset();
    raw = 5'b11111;
    for (int e = 1; e <= 6; e++) begin
      step();
      n_tests++;
      if (rise !== ((e == 6) ? 5'b11111 : 5'b00000)) begin
        n_fail++;
        $display("FAIL all_rise e=%0d got %b exp %b", e, rise, (e == 6) ? 5'b11111 : 5'b00000);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      for (int n = 0; n < C; n++) begin
        if ($urandom_range(9) == 0) raw[n] = ~raw[n];
        clr[n] = ($urandom_range(5) == 0);
      end
      if ($urandom_range(15) == 0) mask = C'($urandom);
      rstn = ($urandom_range(199) != 0);
      step();
      n_tests++;
      if ({level, rise, fall, cap, irq} !== {m_level, m_rise, m_fall, m_cap, m_irq}) begin
        n_fail++;
        $display("FAIL random cyc=%0d got l=%b r=%b f=%b c=%b i=%b exp l=%b r=%b f=%b c=%b i=%b",
                 i, level, rise, fall, cap, irq, m_level, m_rise, m_fall, m_cap, m_irq);
      end
      n_tests++;
      if ((rise & fall) !== '0) begin
        n_fail++;
        $display("FAIL random_rise_fall cyc=%0d got r&f=%b exp 0", i, rise & fall);
      end
    end
    rstn = 1'b1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_step();
    test_glitch();
    test_coincident();
    test_mask();
    test_reset_midcount();
    test_all_channels();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
